// File: rtl/seq_stim_pkg.sv
// Shared definitions for the sequence-detector stimulus transmitter:
// FSM state encoding, default geometry and the length-clamping helper.
package seq_stim_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_GAP   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_t;

    // A zero or oversize length means "send the whole word".
    function automatic int eff_len(input int len, input int width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register with the MSB as serial output.
// Zeros are shifted in at the LSB so a drained register reads all-zero.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             serial_out
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shift_src;

    // Each bit takes its lower neighbour on a shift; bit 0 takes a zero.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_src
        if (gi == 0) begin : g_lsb
            assign shift_src[gi] = 1'b0;
        end else begin : g_mid
            assign shift_src[gi] = q_reg[gi-1];
        end
    end

    // Load has priority over shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_data;
        end else if (shift) begin
            q_reg <= shift_src;
        end
    end

    assign serial_out = q_reg[WIDTH-1];

endmodule

// File: rtl/seq_stim_tx.sv
// Serial stimulus transmitter for the 3-flop sequence detectors.
// Takes a pattern over valid/ready, sends it MSB-first on x_out, pulses
// done, then idles for GAP cycles (done cycle included) before re-arming.
// Optional build macro: SEQ_STIM_TX_PARITY_EN appends an even-parity bit.
// x_out_reg holds the bit on the wire; the shift register holds the
// remaining bits, so its MSB is always the next bit to send.
module seq_stim_tx
    import seq_stim_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    tx_state_t        state_reg, state_next;
    logic [LEN_W-1:0] cnt_reg, cnt_next;
    logic [GAP_W-1:0] gap_reg, gap_next;
    logic             in_ready_reg, in_ready_next;
    logic             busy_reg, busy_next;
    logic             x_valid_reg, x_valid_next;
    logic             x_out_reg, x_out_next;
    logic             done_reg, done_next;

    int               eff_l;
    logic [WIDTH-1:0] load_word;
    logic             sr_load, sr_shift, sr_msb;
    logic             end_frame;

`ifdef SEQ_STIM_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    // Left-justify the pattern so its first bit lands in the MSB.
    always_comb begin
        eff_l     = eff_len(int'(in_len), WIDTH);
        load_word = in_data << (WIDTH - eff_l);
    end

    piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
        .clk        (clk),
        .rst        (rst),
        .load       (sr_load),
        .load_data  ({load_word[WIDTH-2:0], 1'b0}),
        .shift      (sr_shift),
        .serial_out (sr_msb)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        gap_next      = gap_reg;
        in_ready_next = in_ready_reg;
        busy_next     = busy_reg;
        x_valid_next  = x_valid_reg;
        x_out_next    = x_out_reg;
        done_next     = 1'b0;
        sr_load       = 1'b0;
        sr_shift      = 1'b0;
        end_frame     = 1'b0;
`ifdef SEQ_STIM_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                in_ready_next = 1'b1;
                busy_next     = 1'b0;
                x_valid_next  = 1'b0;
                x_out_next    = 1'b0;
                if (in_valid && in_ready_reg) begin
                    state_next    = ST_SHIFT;
                    sr_load       = 1'b1;
                    cnt_next      = LEN_W'(eff_l);
                    in_ready_next = 1'b0;
                    busy_next     = 1'b1;
                    x_valid_next  = 1'b1;
                    x_out_next    = load_word[WIDTH-1];
`ifdef SEQ_STIM_TX_PARITY_EN
                    parity_next   = ^load_word;
`endif
                end
            end
            ST_SHIFT: begin
                sr_shift   = 1'b1;
                cnt_next   = cnt_reg - LEN_W'(1);
                x_out_next = sr_msb;
`ifdef SEQ_STIM_TX_PARITY_EN
                // Counter value 0 marks the extra parity-bit cycle.
                if (cnt_reg == LEN_W'(1)) begin
                    x_out_next = parity_reg;
                end else if (cnt_reg == '0) begin
                    end_frame = 1'b1;
                end
`else
                if (cnt_reg == LEN_W'(1)) begin
                    end_frame = 1'b1;
                end
`endif
                if (end_frame) begin
                    cnt_next     = '0;
                    x_valid_next = 1'b0;
                    x_out_next   = 1'b0;
                    done_next    = 1'b1;
                    if (GAP > 0) begin
                        // The done cycle is the first gap cycle.
                        state_next = ST_GAP;
                        gap_next   = GAP_W'(GAP - 1);
                    end else begin
                        state_next    = ST_IDLE;
                        in_ready_next = 1'b1;
                        busy_next     = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_reg == '0) begin
                    state_next    = ST_IDLE;
                    in_ready_next = 1'b1;
                    busy_next     = 1'b0;
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, counters and output registers; reset discards any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            gap_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b0;
            x_valid_reg  <= 1'b0;
            x_out_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            gap_reg      <= gap_next;
            in_ready_reg <= in_ready_next;
            busy_reg     <= busy_next;
            x_valid_reg  <= x_valid_next;
            x_out_reg    <= x_out_next;
            done_reg     <= done_next;
        end
    end

`ifdef SEQ_STIM_TX_PARITY_EN
    // Parity of the frame, captured with the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

    assign in_ready = in_ready_reg;
    assign busy     = busy_reg;
    assign x_valid  = x_valid_reg;
    assign x_out    = x_out_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_seq_stim_tx.sv
// Directed bench for seq_stim_tx with default WIDTH=8, LEN_W=4, GAP=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_stim_tx;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] in_len;
    logic       x_out;
    logic       x_valid;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SEQ_STIM_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    seq_stim_tx dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_len   (in_len),
        .x_out    (x_out),
        .x_valid  (x_valid),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int i = 0;
        while (in_ready !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        check("wait_ready", 32'(in_ready), 32'd1);
    endtask

    // Send one frame and check every cycle up to re-arm.
    // exp_data holds the n_data expected bits, first bit at [n_data-1].
    task automatic send_frame(input string name, input logic [7:0] data, input logic [3:0] len,
                              input logic [7:0] exp_data, input int n_data, input logic exp_par,
                              input bit scramble);
        int n;
        logic exp_bit;
        n = n_data + (PAR_EN ? 1 : 0);
        wait_ready();
        in_valid = 1'b1;
        in_data  = data;
        in_len   = len;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            exp_bit = (k <= n_data) ? exp_data[n_data - k] : exp_par;
            check($sformatf("%s bit%0d x_out", name, k), 32'(x_out), 32'(exp_bit));
            check($sformatf("%s bit%0d x_valid", name, k), 32'(x_valid), 32'd1);
            check($sformatf("%s bit%0d in_ready", name, k), 32'(in_ready), 32'd0);
            check($sformatf("%s bit%0d busy", name, k), 32'(busy), 32'd1);
            if (scramble && k < n) begin
                in_valid = 1'b1;
                in_data  = ~data ^ 8'(k);
                in_len   = 4'(k);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " done"}, 32'(done), 32'd1);
        check({name, " done x_valid"}, 32'(x_valid), 32'd0);
        check({name, " done x_out"}, 32'(x_out), 32'd0);
        @(negedge clk);
        check({name, " gap2 done"}, 32'(done), 32'd0);
        check({name, " gap2 in_ready"}, 32'(in_ready), 32'd0);
        check({name, " gap2 busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({name, " rearm in_ready"}, 32'(in_ready), 32'd1);
        check({name, " rearm busy"}, 32'(busy), 32'd0);
        $display("frame %s data=%02h len=%0d bits=%0d checked", name, data, len, n);
    endtask

    // Pattern held valid continuously, alternating A5/3C.
    task automatic back_to_back();
        logic [8:0] acc;
        logic [8:0] exp_acc;
        logic [7:0] pat;
        int first_cyc [3];
        int frame_idx = 0;
        bit prev_ir;
        bit prev_xv = 1'b0;
        acc = '0;
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_len   = 4'd8;
        prev_ir  = 1'b1;
        for (int cyc = 0; cyc < 80 && frame_idx < 3; cyc++) begin
            @(negedge clk);
            if (x_valid && !prev_xv) begin
                first_cyc[frame_idx] = cyc;
                acc = '0;
            end
            if (x_valid) acc = {acc[7:0], x_out};
            if (done) begin
                pat = (frame_idx % 2 == 0) ? 8'hA5 : 8'h3C;
                // Both patterns carry four ones, so the parity bit is 0.
                exp_acc = PAR_EN ? {pat, 1'b0} : {1'b0, pat};
                check($sformatf("b2b frame%0d data", frame_idx), 32'(acc), 32'(exp_acc));
                $display("frame b2b%0d data=%02h first_bit_cycle=%0d", frame_idx, pat, first_cyc[frame_idx]);
                frame_idx++;
                if (frame_idx == 3) in_valid = 1'b0;
            end
            if (prev_ir) in_data = (in_data == 8'hA5) ? 8'h3C : 8'hA5;
            prev_ir = in_ready;
            prev_xv = x_valid;
        end
        in_valid = 1'b0;
        check("b2b frame count", 32'(frame_idx), 32'd3);
        if (frame_idx == 3) begin
            check("b2b spacing01", 32'(first_cyc[1] - first_cyc[0]), PAR_EN ? 32'd12 : 32'd11);
            check("b2b spacing12", 32'(first_cyc[2] - first_cyc[1]), PAR_EN ? 32'd12 : 32'd11);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_len   = 4'd0;

        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset x_out", 32'(x_out), 32'd0);
        check("reset x_valid", 32'(x_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first edge in_ready", 32'(in_ready), 32'd1);

        // B2 = 1011_0010 (four ones), parity 0.
        send_frame("b2_len8", 8'hB2, 4'd8, 8'hB2, 8, 1'b0, 1'b0);
        // FF len 3 -> 111, parity 1.
        send_frame("ff_len3", 8'hFF, 4'd3, 8'h07, 3, 1'b1, 1'b0);
        // 01 len 0 -> full width 0000_0001, parity 1.
        send_frame("01_len0", 8'h01, 4'd0, 8'h01, 8, 1'b1, 1'b0);
        // 07 len 3 -> 111, parity 1.
        send_frame("07_len3", 8'h07, 4'd3, 8'h07, 3, 1'b1, 1'b0);
        // C3 len 12 clamps to 8 -> 1100_0011, parity 0.
        send_frame("c3_len12", 8'hC3, 4'd12, 8'hC3, 8, 1'b0, 1'b0);
        // 01 len 1 -> single bit 1, parity 1.
        send_frame("01_len1", 8'h01, 4'd1, 8'h01, 1, 1'b1, 1'b0);
        // 5A len 6 -> 01_1010 with inputs churning during the frame, parity 1.
        send_frame("5a_len6_scr", 8'h5A, 4'd6, 8'h1A, 6, 1'b1, 1'b1);

        back_to_back();

        // Reset after the fourth bit of F0.
        wait_ready();
        in_valid = 1'b1;
        in_data  = 8'hF0;
        in_len   = 4'd8;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("f0 bit%0d x_out", k), 32'(x_out), 32'd1);
        end
        rst = 1'b1;
        #1;
        check("async rst x_out", 32'(x_out), 32'd0);
        check("async rst x_valid", 32'(x_valid), 32'd0);
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst in_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst hold done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post rst done", 32'(done), 32'd0);
        $display("frame f0_reset aborted after 4 bits checked");
        // 0F = 0000_1111 (four ones), parity 0.
        send_frame("0f_after_rst", 8'h0F, 4'd8, 8'h0F, 8, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
